ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one port of the on-chip `dual_port_ram` between two Frodo datapath masters, for example the matrix generator and the error sampler. Per access, it grants one beat with round-robin fairness. A master can hold the port for a locked burst, up to `MAX_BURST` beats. The arbiter drives the RAM port's write-enable, address and data, and returns read data with a `rvalid` strobe one cycle after the read is accepted.

---
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_ram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one dual_port_ram port between two masters,
// with optional locked bursts capped at MAX_BURST beats per tenure.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,

    output logic [1:0]            owner
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    // Encodings double as the owner status value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic             grant0;
    logic             grant1;
    logic             beat;
    logic             sel;
    logic             sel_lock;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the master that was not served last wins.
                grant0 = m0_valid & (~m1_valid | last);
                grant1 = m1_valid & (~m0_valid | ~last);
            end
            OWN0:    grant0 = m0_valid;
            OWN1:    grant1 = m1_valid;
            default: ;
        endcase
    end

    assign beat     = grant0 | grant1;
    assign sel      = grant1;
    assign sel_lock = sel ? m1_lock : m0_lock;
    assign cnt_inc  = cnt + CNT_W'(1);

    assign m0_ready = grant0;
    assign m1_ready = grant1;

    // With no beat the port performs a harmless read of address 0.
    assign ram_we   = beat & (sel ? m1_we : m0_we);
    assign ram_addr = !beat ? '0 : (sel ? m1_addr  : m0_addr);
    assign ram_din  = !beat ? '0 : (sel ? m1_wdata : m0_wdata);

    assign m0_rdata = ram_dout;
    assign m1_rdata = ram_dout;
    assign owner    = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= grant0 & ~m0_we;
            m1_rvalid <= grant1 & ~m1_we;
            if (beat) begin
                last <= sel;
                if (sel_lock && (cnt_inc < CNT_MAX)) begin
                    state <= sel ? OWN1 : OWN0;
                    cnt   <= cnt_inc;
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else if ((state == OWN0 && !m0_lock) || (state == OWN1 && !m1_lock)) begin
                // Owner went quiet and dropped lock: give the port back.
                state <= IDLE;
                cnt   <= '0;
                last  <= (state == OWN1);
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a behavioural RAM
// and a reference memory.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_valid, m0_we, m0_lock, m0_ready, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_we, m1_lock, m1_ready, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [1:0]    owner;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .owner(owner)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 64'hA5A5_0000_0000_0000 | {52'd0, a};
    endfunction

    // Behavioural RAM port: registered read, unwritten words return init_val.
    logic [DW-1:0] mem [0:63];
    logic [63:0]   written = '0;
    always @(posedge clk) begin
        ram_dout <= written[ram_addr[5:0]] ? mem[ram_addr[5:0]] : init_val(ram_addr);
        if (ram_we) begin
            mem[ram_addr[5:0]]     <= ram_din;
            written[ram_addr[5:0]] <= 1'b1;
        end
    end

    // Reference memory for the random run.
    logic [DW-1:0] ref_mem [0:63];
    logic [63:0]   ref_ok = '0;

    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
        return ref_ok[a[5:0]] ? ref_mem[a[5:0]] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_lock = 0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0r[9]  = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
        int e1r[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        int eown[9] = '{0, 1, 1, 1, 0, 0, 1, 1, 0};
        int f0r[6]  = '{0, 0, 0, 0, 0, 1};
        int f1r[6]  = '{1, 0, 0, 0, 0, 0};
        int fown[6] = '{0, 2, 2, 2, 2, 0};
        int m0beats, m1beats, prev0, prev_beat;
        logic          pv0, pwe0, pv1, pwe1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1, exp_d0, exp_d1;
        logic          exp_rv0, exp_rv1;
        int            wait0, wait1;

        // Reset state
        rstn = 0;
        idle_inputs();
        tick(); tick();
        settle();
        chk("rst_owner", owner, 2'b00);
        chk("rst_rv0", m0_rvalid, 0);
        chk("rst_rv1", m1_rvalid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        tick();
        rstn = 1;
        tick();

        // Tie of two reads: m0 first, then m1
        m0_valid = 1; m0_addr = 12'd5;
        m1_valid = 1; m1_addr = 12'd9;
        settle();
        chk("tie_m0_ready", m0_ready, 1);
        chk("tie_m1_ready", m1_ready, 0);
        chk("tie_ram_addr0", ram_addr, 12'd5);
        tick();
        m0_valid = 0;
        settle();
        chk("tie_m1_ready2", m1_ready, 1);
        chk("tie_ram_addr1", ram_addr, 12'd9);
        chk("tie_m0_rvalid", m0_rvalid, 1);
        chk("tie_m0_rdata", m0_rdata, init_val(12'd5));
        tick();
        m1_valid = 0;
        settle();
        chk("tie_m1_rvalid", m1_rvalid, 1);
        chk("tie_m1_rdata", m1_rdata, init_val(12'd9));
        chk("tie_m0_rvalid_off", m0_rvalid, 0);
        tick();

        // Read-after-write on m0
        m0_valid = 1; m0_we = 1; m0_addr = 12'd3; m0_wdata = 64'hDEAD;
        settle();
        chk("raw_wr_ready", m0_ready, 1);
        chk("raw_ram_we", ram_we, 1);
        chk("raw_ram_din", ram_din, 64'hDEAD);
        tick();
        m0_we = 0; m0_wdata = '0;
        settle();
        chk("raw_rd_ready", m0_ready, 1);
        chk("raw_no_rv_for_write", m0_rvalid, 0);
        chk("raw_rd_ram_we", ram_we, 0);
        tick();
        idle_inputs();
        settle();
        chk("raw_rvalid", m0_rvalid, 1);
        chk("raw_rdata", m0_rdata, 64'hDEAD);
        tick();

        // Single m1 write so that m1 is last served before the burst test
        m1_valid = 1; m1_we = 1; m1_addr = 12'd2; m1_wdata = 64'h1234;
        settle();
        chk("pre_m1_ready", m1_ready, 1);
        tick();
        idle_inputs();
        tick();

        // Locked burst from m0 capped at MB beats, m1 waiting
        m0beats = 0; m1beats = 0; prev0 = 0; prev_beat = 0;
        for (int c = 0; c < 9; c++) begin
            m0_valid = (m0beats < 6); m0_lock = (m0beats < 6);
            m0_addr  = 12'h010 + AW'(m0beats);
            m1_valid = (m1beats < 2); m1_addr = 12'h020;
            settle();
            chk($sformatf("burst_m0_ready_c%0d", c), m0_ready, e0r[c]);
            chk($sformatf("burst_m1_ready_c%0d", c), m1_ready, e1r[c]);
            chk($sformatf("burst_owner_c%0d", c), owner, eown[c]);
            chk($sformatf("burst_m0_rvalid_c%0d", c), m0_rvalid, prev0);
            if (prev0 == 1)
                chk($sformatf("burst_m0_rdata_c%0d", c), m0_rdata, init_val(12'h010 + AW'(prev_beat)));
            prev0 = m0_ready ? 1 : 0;
            prev_beat = m0beats;
            if (m0_ready) m0beats++;
            if (m1_ready) m1beats++;
            tick();
        end
        idle_inputs();
        tick();

        // OWN1 held idle with lock; m0 blocked until lock drops
        for (int c = 0; c < 6; c++) begin
            m1_valid = (c == 0); m1_addr = 12'h030; m1_lock = (c < 4);
            m0_valid = (c >= 1); m0_addr = 12'h031;
            settle();
            chk($sformatf("hold_m0_ready_c%0d", c), m0_ready, f0r[c]);
            chk($sformatf("hold_m1_ready_c%0d", c), m1_ready, f1r[c]);
            chk($sformatf("hold_owner_c%0d", c), owner, fown[c]);
            tick();
        end
        idle_inputs();
        tick();

        // Reset in the middle of a locked read burst
        m0_valid = 1; m0_lock = 1; m0_addr = 12'h011;
        settle();
        chk("rstb_ready0", m0_ready, 1);
        tick();
        m0_addr = 12'h012;
        settle();
        chk("rstb_ready1", m0_ready, 1);
        chk("rstb_owner_pre", owner, 2'b01);
        chk("rstb_rvalid_pre", m0_rvalid, 1);
        rstn = 0;
        idle_inputs();
        #1;
        chk("rstb_rvalid_async", m0_rvalid, 0);
        chk("rstb_owner_async", owner, 2'b00);
        tick();
        settle();
        chk("rstb_rvalid_held", m0_rvalid, 0);
        chk("rstb_owner_held", owner, 2'b00);
        tick();
        rstn = 1;
        m0_valid = 1; m0_addr = 12'h021;
        m1_valid = 1; m1_addr = 12'h022;
        settle();
        chk("rstb_tie_m0", m0_ready, 1);
        chk("rstb_tie_m1", m1_ready, 0);
        tick();
        idle_inputs();
        settle();
        chk("rstb_tie_rvalid", m0_rvalid, 1);
        chk("rstb_tie_rdata", m0_rdata, init_val(12'h021));
        tick();

        // Random traffic against the reference memory
        pv0 = 0; pwe0 = 0; pa0 = '0; pd0 = '0;
        pv1 = 0; pwe1 = 0; pa1 = '0; pd1 = '0;
        exp_rv0 = 0; exp_rv1 = 0; exp_d0 = '0; exp_d1 = '0;
        wait0 = 0; wait1 = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!pv0) begin
                pv0 = ($urandom_range(0, 2) != 0); pwe0 = $urandom_range(0, 1) == 1;
                pa0 = 12'h020 + AW'($urandom_range(0, 15)); pd0 = {$urandom(), $urandom()};
            end
            if (!pv1) begin
                pv1 = ($urandom_range(0, 2) != 0); pwe1 = $urandom_range(0, 1) == 1;
                pa1 = 12'h020 + AW'($urandom_range(0, 15)); pd1 = {$urandom(), $urandom()};
            end
            m0_valid = pv0; m0_we = pwe0; m0_addr = pa0; m0_wdata = pd0;
            m0_lock  = pv0 & ($urandom_range(0, 1) == 1);
            m1_valid = pv1; m1_we = pwe1; m1_addr = pa1; m1_wdata = pd1;
            m1_lock  = pv1 & ($urandom_range(0, 1) == 1);
            settle();
            chk("rnd_rv0", m0_rvalid, exp_rv0);
            if (exp_rv0) chk("rnd_rdata0", m0_rdata, exp_d0);
            chk("rnd_rv1", m1_rvalid, exp_rv1);
            if (exp_rv1) chk("rnd_rdata1", m1_rdata, exp_d1);
            chk("rnd_exclusive", m0_ready & m1_ready, 0);
            exp_rv0 = 0; exp_rv1 = 0;
            if (m0_ready) begin
                chk("rnd_ram_we0", ram_we, pwe0);
                chk("rnd_ram_addr0", ram_addr, pa0);
                if (pwe0) begin
                    chk("rnd_ram_din0", ram_din, pd0);
                    ref_mem[pa0[5:0]] = pd0; ref_ok[pa0[5:0]] = 1'b1;
                end else begin
                    exp_rv0 = 1; exp_d0 = ref_val(pa0);
                end
                pv0 = 0; wait0 = 0;
            end else if (m1_ready) begin
                chk("rnd_ram_we1", ram_we, pwe1);
                chk("rnd_ram_addr1", ram_addr, pa1);
                if (pwe1) begin
                    chk("rnd_ram_din1", ram_din, pd1);
                    ref_mem[pa1[5:0]] = pd1; ref_ok[pa1[5:0]] = 1'b1;
                end else begin
                    exp_rv1 = 1; exp_d1 = ref_val(pa1);
                end
            end else begin
                chk("rnd_idle_we", ram_we, 0);
                chk("rnd_idle_addr", ram_addr, 0);
            end
            if (m1_ready) begin
                pv1 = 0; wait1 = 0;
            end
            if (pv0 && !m0_ready) begin
                wait0++;
                chk("rnd_wait0", wait0 <= MB + 1, 1);
            end
            if (pv1 && !m1_ready) begin
                wait1++;
                chk("rnd_wait1", wait1 <= MB + 1, 1);
            end
            tick();
        end
        idle_inputs();
        settle();
        chk("rnd_final_rv0", m0_rvalid, exp_rv0);
        chk("rnd_final_rv1", m1_rvalid, exp_rv1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
